// File: rtl/stack_ctrl_if.sv
// Command/response/status bundle between a command source and stack_ctrl.
interface stack_ctrl_if #(
  parameter int unsigned STACK_WIDTH = 18,
  parameter int unsigned DEPTH       = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [1:0]             i_cmd_op;
  logic [STACK_WIDTH-1:0] i_cmd_data;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready;
  logic [STACK_WIDTH-1:0] o_rsp_data;
  logic [CW-1:0]          o_count;
  logic                   o_empty;
  logic                   o_full;
  logic                   o_ovf;

  modport master (
    output i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
    input  o_cmd_ready, o_rsp_valid, o_rsp_data, o_count, o_empty, o_full, o_ovf
  );

  modport slave (
    input  i_cmd_valid, i_cmd_op, i_cmd_data, i_rsp_ready,
    output o_cmd_ready, o_rsp_valid, o_rsp_data, o_count, o_empty, o_full, o_ovf
  );
endinterface

// File: rtl/stack_ctrl.sv
// Flow-controlled sequencer around a raw circular stack: push/pop/replace/flush
// commands, occupancy tracking and a registered popped-word response channel.
module stack #(
  parameter int unsigned W     = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] ptr_q, ptr_d, top;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [W-1:0]  data_q, data_d;

  // Pointer wraps modulo DEPTH; push+pop swaps the top word in place.
  always_comb begin
    top    = ptr_q - AW'(1);
    ptr_d  = ptr_q;
    data_d = data_q;
    mem_d  = mem_q;
    if (i_push && i_pop) begin
      data_d     = mem_q[top];
      mem_d[top] = i_data;
    end else if (i_push) begin
      mem_d[ptr_q] = i_data;
      ptr_d        = ptr_q + AW'(1);
    end else if (i_pop) begin
      data_d = mem_q[top];
      ptr_d  = top;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q  <= '0;
      data_q <= '0;
      mem_q  <= '{default: '0};
    end else begin
      ptr_q  <= ptr_d;
      data_q <= data_d;
      mem_q  <= mem_d;
    end
  end

  assign o_data = data_q;
endmodule

module stack_ctrl #(
  parameter int unsigned STACK_WIDTH = 18,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned OVERWRITE   = 0
) (
  input logic         i_clk,
  input logic         i_rst,
  stack_ctrl_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_REPL  = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  typedef enum logic [1:0] {IDLE, RESP, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic          op_legal, can_take, cmd_ready_c, accept;
  logic          stk_push, stk_pop, stk_flush;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_flush = 1'b0;

    unique case (bus.i_cmd_op)
      OP_PUSH:  op_legal = !full_q || (OVERWRITE != 0);
      OP_POP,
      OP_REPL:  op_legal = !empty_q;
      default:  op_legal = 1'b1;
    endcase

    can_take    = (state_q == IDLE) || ((state_q == RESP) && bus.i_rsp_ready);
    cmd_ready_c = can_take && op_legal;
    accept      = bus.i_cmd_valid && cmd_ready_c;

    if (accept) begin
      unique case (bus.i_cmd_op)
        OP_PUSH: begin
          stk_push = 1'b1;
          if (full_q) ovf_d = 1'b1;
          else        count_d = count_q + CW'(1);
        end
        OP_POP: begin
          stk_pop = 1'b1;
          count_d = count_q - CW'(1);
        end
        OP_REPL: begin
          stk_push = 1'b1;
          stk_pop  = 1'b1;
        end
        default: begin
          stk_flush = 1'b1;
          count_d   = '0;
          ovf_d     = 1'b0;
        end
      endcase
    end

    // A pending response blocks everything until the consumer takes it.
    case (state_q)
      IDLE, RESP: begin
        if ((state_q == IDLE) || bus.i_rsp_ready) begin
          state_d = IDLE;
          if (stk_pop)   state_d = RESP;
          if (stk_flush) state_d = FLUSH;
        end
      end
      default: state_d = IDLE;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  stack #(.W(STACK_WIDTH), .DEPTH(DEPTH)) u_stack (
    .i_clk  (i_clk),
    .i_rst  (i_rst | stk_flush),
    .i_push (stk_push),
    .i_pop  (stk_pop),
    .i_data (bus.i_cmd_data),
    .o_data (bus.o_rsp_data)
  );

  assign bus.o_cmd_ready = cmd_ready_c;
  assign bus.o_rsp_valid = (state_q == RESP);
  assign bus.o_count     = count_q;
  assign bus.o_empty     = empty_q;
  assign bus.o_full      = full_q;
  assign bus.o_ovf       = ovf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Table-driven bench for stack_ctrl (OVERWRITE=0 and 1 instances) with a
// LIFO reference model and a response scoreboard.
module tb_stack_ctrl;
  localparam int unsigned W     = 18;
  localparam int unsigned DEPTH = 4;
  localparam logic [1:0] PUSH = 2'd0, POP = 2'd1, REPL = 2'd2, FLUSH = 2'd3;

  typedef struct {
    bit         rst;
    bit         sel;
    bit         v;
    logic [1:0] op;
    logic [W-1:0] d;
    bit         rr;
    bit         er;
  } vec_t;

  logic clk, rst, sel;
  logic cv, rr;
  logic [1:0] cop;
  logic [W-1:0] cdata;
  logic rdy, rsp_v, empty, full, ovf;
  logic [W-1:0] rsp_d;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  logic [W-1:0] mstk[$];
  logic [W-1:0] sb[$];
  bit movf, mow;

  stack_ctrl_if #(.STACK_WIDTH(W), .DEPTH(DEPTH)) if0 ();
  stack_ctrl_if #(.STACK_WIDTH(W), .DEPTH(DEPTH)) if1 ();

  stack_ctrl #(.STACK_WIDTH(W), .DEPTH(DEPTH), .OVERWRITE(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .bus(if0));
  stack_ctrl #(.STACK_WIDTH(W), .DEPTH(DEPTH), .OVERWRITE(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .bus(if1));

  assign if0.i_cmd_valid = cv & ~sel;
  assign if1.i_cmd_valid = cv & sel;
  assign if0.i_cmd_op    = cop;
  assign if1.i_cmd_op    = cop;
  assign if0.i_cmd_data  = cdata;
  assign if1.i_cmd_data  = cdata;
  assign if0.i_rsp_ready = sel ? 1'b1 : rr;
  assign if1.i_rsp_ready = sel ? rr : 1'b1;
  assign rdy   = sel ? if1.o_cmd_ready : if0.o_cmd_ready;
  assign rsp_v = sel ? if1.o_rsp_valid : if0.o_rsp_valid;
  assign rsp_d = sel ? if1.o_rsp_data  : if0.o_rsp_data;
  assign count = sel ? if1.o_count     : if0.o_count;
  assign empty = sel ? if1.o_empty     : if0.o_empty;
  assign full  = sel ? if1.o_full      : if0.o_full;
  assign ovf   = sel ? if1.o_ovf       : if0.o_ovf;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input bit v, input logic [1:0] op, input logic [W-1:0] d,
                     input bit r, input bit er);
    tbl.push_back('{rst: 1'b0, sel: 1'b0, v: v, op: op, d: d, rr: r, er: er});
  endtask

  task automatic add_rst(input bit s);
    tbl.push_back('{rst: 1'b1, sel: s, v: 1'b0, op: PUSH, d: '0, rr: 1'b1, er: 1'b0});
  endtask

  task automatic model_clear(input bit s);
    mstk.delete();
    sb.delete();
    movf = 1'b0;
    mow  = s;
  endtask

  task automatic do_reset(input bit s);
    @(negedge clk);
    sel = s; rst = 1'b1; cv = 1'b0; rr = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear(s);
    chk("reset_rsp_valid", 32'(rsp_v), 32'd0);
    chk("reset_rsp_data", 32'(rsp_d), 32'd0);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_ovf", 32'(ovf), 32'd0);
  endtask

  // One cycle: drive, check outputs against the model, then advance the model.
  task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] d,
                      input bit r, input bit er);
    logic [W-1:0] top;
    @(negedge clk);
    cv = v; cop = op; cdata = d; rr = r;
    #1;
    chk("cmd_ready", 32'(rdy), 32'(er));
    chk("count", 32'(count), 32'(mstk.size()));
    chk("empty", 32'(empty), 32'(mstk.size() == 0));
    chk("full", 32'(full), 32'(mstk.size() == DEPTH));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("rsp_valid", 32'(rsp_v), 32'(sb.size() > 0));
    if (sb.size() > 0) chk("rsp_data", 32'(rsp_d), 32'(sb[0]));
    @(posedge clk);
    if (sb.size() > 0 && r) void'(sb.pop_front());
    if (v && er) begin
      case (op)
        PUSH: begin
          if (mstk.size() == DEPTH) begin
            void'(mstk.pop_front());
            movf = 1'b1;
          end
          mstk.push_back(d);
        end
        POP:  sb.push_back(mstk.pop_back());
        REPL: begin
          top = mstk[mstk.size()-1];
          sb.push_back(top);
          mstk[mstk.size()-1] = d;
        end
        default: begin
          mstk.delete();
          movf = 1'b0;
        end
      endcase
    end
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; cv = 1'b0; rr = 1'b1; cop = PUSH; cdata = '0;
    model_clear(1'b0);

    // LIFO order and back-to-back pops
    add_rst(0);
    add(1, PUSH, 18'h00011, 1, 1);
    add(1, PUSH, 18'h00022, 1, 1);
    add(1, PUSH, 18'h00033, 1, 1);
    add(1, POP,  '0, 1, 1);
    add(1, POP,  '0, 1, 1);
    add(1, POP,  '0, 1, 1);
    add(0, POP,  '0, 1, 0);
    add(0, POP,  '0, 1, 0);
    // pop on empty stalls
    for (int i = 0; i < 5; i++) add(1, POP, '0, 1, 0);
    add(1, PUSH, 18'h00005, 1, 1);
    add(1, POP,  '0, 1, 1);
    add(0, POP,  '0, 1, 0);
    add(0, POP,  '0, 1, 0);
    // full, no overwrite
    add_rst(0);
    for (int i = 1; i <= 4; i++) add(1, PUSH, W'(i), 1, 1);
    add(1, PUSH, 18'd5, 1, 0);
    add(1, PUSH, 18'd5, 1, 0);
    add(1, POP,  '0, 1, 1);
    add(1, PUSH, 18'd5, 1, 1);
    add(0, POP,  '0, 1, 1);
    // full, overwrite; then flush
    add_rst(1);
    for (int i = 1; i <= 6; i++) add(1, PUSH, W'(i), 1, 1);
    for (int i = 0; i < 4; i++) add(1, POP, '0, 1, 1);
    add(1, PUSH,  18'd9, 1, 1);
    add(1, FLUSH, '0, 1, 1);
    add(1, PUSH,  18'd8, 1, 0);
    add(1, PUSH,  18'd7, 1, 1);
    add(0, POP,   '0, 1, 1);
    // replace
    add_rst(0);
    add(1, PUSH, 18'h0000A, 1, 1);
    add(1, REPL, 18'h0000B, 1, 1);
    add(1, POP,  '0, 1, 1);
    add(0, POP,  '0, 1, 0);
    add(0, POP,  '0, 1, 0);
    // response backpressure
    add_rst(0);
    add(1, PUSH, 18'h00123, 1, 1);
    add(1, PUSH, 18'h00456, 1, 1);
    add(1, POP,  '0, 0, 1);
    for (int i = 0; i < 3; i++) add(1, POP, '0, 0, 0);
    add(0, POP,  '0, 1, 1);
    add(0, POP,  '0, 1, 1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset(tbl[i].sel);
      else step(tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].rr, tbl[i].er);
    end

    // reset while a response is pending drops it
    do_reset(0);
    step(1, PUSH, 18'h00077, 1, 1);
    step(1, POP,  '0, 0, 1);
    @(negedge clk);
    rst = 1'b1; cv = 1'b0; rr = 1'b0;
    #1;
    chk("pending_rsp_valid", 32'(rsp_v), 32'd1);
    chk("pending_rsp_data", 32'(rsp_d), 32'h77);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear(0);
    chk("rst_drop_rsp_valid", 32'(rsp_v), 32'd0);
    chk("rst_drop_count", 32'(count), 32'd0);
    step(1, PUSH, 18'h00001, 1, 1);
    step(0, POP,  '0, 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
